// File: rtl/seg7_pkg.sv
// ============================================================================
// Module      : seg7_pkg
// Description : Shared definitions for the 7-segment scan controller:
//               scan state encoding, ceiling-log2 helper and the inactive
//               output patterns derived from pin polarity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  // Scan state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  // Ceiling log2, never smaller than 1 so a counter always has a bit
  function automatic int clog2(input int value);
    int res;
    res = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  // Segment pattern that lights nothing for the given polarity
  function automatic logic [6:0] seg_inactive(input bit active_low);
    return active_low ? 7'h7F : 7'h00;
  endfunction

  // Decimal point level that lights nothing for the given polarity
  function automatic logic dp_inactive(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage : seg7_pkg

`default_nettype wire

// File: rtl/seg7_decoder.sv
// ============================================================================
// Module      : seg7_decoder
// Description : BCD nibble to 7-segment pattern {a,b,c,d,e,f,g}. Values
//               above 9 show a dash (segment g only).
// Ports       : bcd_i [3:0] - nibble to decode
//               seg_o [6:0] - segment pattern at the configured polarity
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decoder #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  logic [6:0] seg_on;  // active-high pattern

  always_comb begin
    seg_on = 7'b0000001;
    case (bcd_i)
      4'd0:    seg_on = 7'b1111110;
      4'd1:    seg_on = 7'b0110000;
      4'd2:    seg_on = 7'b1101101;
      4'd3:    seg_on = 7'b1111001;
      4'd4:    seg_on = 7'b0110011;
      4'd5:    seg_on = 7'b1011011;
      4'd6:    seg_on = 7'b1011111;
      4'd7:    seg_on = 7'b1110000;
      4'd8:    seg_on = 7'b1111111;
      4'd9:    seg_on = 7'b1111011;
      default: seg_on = 7'b0000001;
    endcase
  end

  assign seg_o = SEG_ACTIVE_LOW ? ~seg_on : seg_on;

endmodule : seg7_decoder

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : Time-multiplexed scan controller for an N-digit 7-segment
//               display. Each digit slot is a dark blanking gap followed by
//               the lit digit; inputs are snapshotted once per frame and
//               leading zeros can be suppressed.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               digits_i        - packed BCD, digit k at [4k+3:4k]
//               dp_i            - decimal point request per digit
//               lz_blank_i      - leading-zero suppression enable
//               enable_i        - run the scan (dark when low)
//               seg_o, dp_o     - segments {a..g} and decimal point
//               an_o            - digit anodes
//               frame_o         - one-cycle pulse at each frame start
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int CLK_HZ         = 50_000_000,
  parameter int REFRESH_HZ     = 1000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic                  lz_blank_i,
  input  logic                  enable_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic                  frame_o
);

  localparam int SLOT_CYC = CLK_HZ / (REFRESH_HZ * N_DIGITS);
  localparam int CNT_W    = clog2(SLOT_CYC);
  localparam int IDX_W    = clog2(N_DIGITS);

  localparam logic [CNT_W-1:0]    CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_SLOT_LAST  = CNT_W'(SLOT_CYC - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST       = IDX_W'(N_DIGITS - 1);
  localparam logic [6:0]          SEG_OFF        = seg_inactive(SEG_ACTIVE_LOW);
  localparam logic                DP_OFF         = dp_inactive(SEG_ACTIVE_LOW);
  localparam logic [N_DIGITS-1:0] AN_OFF         = {N_DIGITS{AN_ACTIVE_LOW}};

  if ((N_DIGITS < 2) || (N_DIGITS > 8) || (BLANK_CYCLES < 1) ||
      (SLOT_CYC < BLANK_CYCLES + 1)) begin : g_bad_params
    $error("seg7_scan_ctrl: illegal parameter combination");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [N_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                  snap_lz_q, snap_lz_d;

  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_q, frame_d;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    snap_digits_d = snap_digits_q;
    snap_dp_d     = snap_dp_q;
    snap_lz_d     = snap_lz_q;

    if (!enable_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d       = ST_BLANK;
          cnt_d         = '0;
          idx_d         = '0;
          snap_digits_d = digits_i;
          snap_dp_d     = dp_i;
          snap_lz_d     = lz_blank_i;
        end
        ST_BLANK: begin
          // cnt runs across the whole slot; the gap ends part way through
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_BLANK_LAST) begin
            state_d = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (cnt_q == CNT_SLOT_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              // New frame: capture all inputs together so a frame never tears
              idx_d         = '0;
              snap_digits_d = digits_i;
              snap_dp_d     = dp_i;
              snap_lz_d     = lz_blank_i;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Leading-zero suppression: digit k blanks when it and every digit above
  // it are zero. Digit 0 is never touched.
  // --------------------------------------------------------------------------
  logic [N_DIGITS-1:0] digit_sup;

  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    digit_sup  = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      upper_zero   = upper_zero & (snap_digits_q[4*k +: 4] == 4'd0);
      digit_sup[k] = snap_lz_q & upper_zero;
    end
  end

  // --------------------------------------------------------------------------
  // Shared decoder on the currently selected snapshot digit
  // --------------------------------------------------------------------------
  logic [3:0] cur_nibble;
  logic [6:0] dec_seg;
  logic       cur_dp;
  logic       cur_sup;

  assign cur_nibble = snap_digits_q[4*idx_q +: 4];
  assign cur_dp     = snap_dp_q[idx_q];
  assign cur_sup    = digit_sup[idx_q];

  seg7_decoder #(
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_dec (
    .bcd_i (cur_nibble),
    .seg_o (dec_seg)
  );

  // --------------------------------------------------------------------------
  // Output register stage: blanking/suppression force the inactive pattern
  // --------------------------------------------------------------------------
  always_comb begin
    logic [N_DIGITS-1:0] an_onehot;
    an_onehot        = '0;
    an_onehot[idx_q] = 1'b1;

    an_d    = AN_OFF;
    seg_d   = SEG_OFF;
    dp_d    = DP_OFF;
    frame_d = (state_q == ST_BLANK) && (idx_q == '0) && (cnt_q == '0);

    if (state_q == ST_SHOW) begin
      // A suppressed digit still lights its anode if it carries a dp
      if (!cur_sup || cur_dp) begin
        an_d = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
      end
      if (!cur_sup) begin
        seg_d = dec_seg;
      end
      if (cur_dp) begin
        dp_d = ~DP_OFF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      snap_lz_q     <= 1'b0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_OFF;
      dp_q          <= DP_OFF;
      frame_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
      snap_lz_q     <= snap_lz_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_q       <= frame_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;

endmodule : seg7_scan_ctrl

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// Module      : tb_seg7_scan_ctrl
// Description : Self-checking bench for seg7_scan_ctrl with a 6-cycle slot
//               (2 dark + 4 lit), 4 digits, active-low segments and anodes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_ctrl;

  localparam int N = 4;

  // Active-low segment patterns {a..g}
  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SD = 7'b1111110;
  localparam logic [6:0] SX = 7'b1111111;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   digits_i;
  logic [N-1:0]  dp_i;
  logic          lz_blank_i;
  logic          enable_i;
  logic [6:0]    seg_o;
  logic          dp_o;
  logic [N-1:0]  an_o;
  logic          frame_o;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .N_DIGITS       (N),
    .CLK_HZ         (1200),
    .REFRESH_HZ     (50),
    .BLANK_CYCLES   (2),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_i   (digits_i),
    .dp_i       (dp_i),
    .lz_blank_i (lz_blank_i),
    .enable_i   (enable_i),
    .seg_o      (seg_o),
    .dp_o       (dp_o),
    .an_o       (an_o),
    .frame_o    (frame_o)
  );

  // One stimulus record: inputs plus per-slot lit-phase outputs
  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        lz;
    logic [15:0] an;    // slot s at [4s+3:4s]
    logic [27:0] seg;   // slot s at [7s+6:7s]
    logic [3:0]  dpo;   // dp_o level during slot s lit cycles
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fr;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, " an"},    32'(an_o),    32'hF);
    chk({tag, " seg"},   32'(seg_o),   32'h7F);
    chk({tag, " dp"},    32'(dp_o),    32'h1);
    chk({tag, " frame"}, 32'(frame_o), 32'h0);
  endtask

  task automatic drive(input vec_t v);
    digits_i   = v.digits;
    dp_i       = v.dp;
    lz_blank_i = v.lz;
  endtask

  // Expected 24 output cycles of one frame
  task automatic push_frame(input vec_t v);
    exp_t e;
    for (int s = 0; s < N; s++) begin
      for (int c = 0; c < 6; c++) begin
        if (c >= 2) begin
          e.an  = v.an[4*s +: 4];
          e.seg = v.seg[7*s +: 7];
          e.dp  = v.dpo[s];
        end else begin
          e.an  = 4'hF;
          e.seg = SX;
          e.dp  = 1'b1;
        end
        e.fr = (s == 0) && (c == 0);
        sb.push_back(e);
      end
    end
  endtask

  // Entered at the sample point of frame cycle 0; leaves at the next frame's
  // cycle 0. Optionally changes inputs during digit-2 lit phase.
  task automatic run_frame(input vec_t cur, input bit has_next, input vec_t nxt,
                           input string tag);
    exp_t  e;
    string t;
    push_frame(cur);
    for (int c = 0; c < 24; c++) begin
      e = sb.pop_front();
      t = $sformatf("%s c%0d", tag, c);
      chk({t, " an"},    32'(an_o),    32'(e.an));
      chk({t, " seg"},   32'(seg_o),   32'(e.seg));
      chk({t, " dp"},    32'(dp_o),    32'(e.dp));
      chk({t, " frame"}, 32'(frame_o), 32'(e.fr));
      if (has_next && c == 14) drive(nxt);
      @(negedge clk);
    end
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    while (frame_o !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (frame_o !== 1'b1) begin
      bad++;
      $display("FAIL %s: frame_o timeout got %b want 1", tag, frame_o);
    end
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 1'b0, 16'h7BDE, {S1, S2, S3, S4}, 4'b1111};
    vecs[1] = '{16'h9876, 4'b0000, 1'b0, 16'h7BDE, {S9, S8, S7, S6}, 4'b1111};
    vecs[2] = '{16'h0005, 4'b0000, 1'b1, 16'hFFFE, {SX, SX, SX, S5}, 4'b1111};
    vecs[3] = '{16'h0000, 4'b0000, 1'b1, 16'hFFFE, {SX, SX, SX, S0}, 4'b1111};
    vecs[4] = '{16'h000A, 4'b0001, 1'b0, 16'h7BDE, {S0, S0, S0, SD}, 4'b1110};
    vecs[5] = '{16'h0305, 4'b1000, 1'b1, 16'h7BDE, {SX, S3, S0, S5}, 4'b0111};

    // Reset held with enable high: reset must win
    rst      = 1'b1;
    enable_i = 1'b1;
    drive(vecs[0]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_dark($sformatf("reset%0d", i));
    end

    // Release: first output cycle is still dark, then frame pulse
    rst = 1'b0;
    @(negedge clk);
    chk_dark("post-reset");
    wait_frame("first frame");

    // Table: each frame shows its vector; next vector is applied mid-frame
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i], (i < 5), vecs[(i + 1) % 6], $sformatf("vec%0d", i));
    end

    // Enable drop during digit-2 lit phase (vecs[5] still displayed)
    repeat (15) @(negedge clk);
    chk("en pre an",  32'(an_o),  32'hB);
    chk("en pre seg", 32'(seg_o), 32'(S3));
    enable_i = 1'b0;
    @(negedge clk);
    chk("en +1 an", 32'(an_o), 32'hB);
    @(negedge clk);
    chk_dark("en +2");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_dark($sformatf("idle%0d", i));
    end

    // Re-enable, then reset pulse during digit-2 lit phase
    drive(vecs[0]);
    enable_i = 1'b1;
    @(negedge clk);
    chk_dark("re-en");
    wait_frame("re-en frame");
    repeat (14) @(negedge clk);
    chk("rst pre an",  32'(an_o),  32'hB);
    chk("rst pre seg", 32'(seg_o), 32'(S2));
    rst = 1'b1;
    @(negedge clk);
    chk_dark("rst pulse");
    rst = 1'b0;
    @(negedge clk);
    chk_dark("rst rel");
    @(negedge clk);
    run_frame(vecs[0], 1'b0, vecs[0], "after rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seg7_scan_ctrl

`default_nettype wire
